// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions used by the receive and transmit paths.
// Latency: n/a (constants, types and elaboration-time helper functions only).
// Backpressure: n/a. Provides DIV rounding, clog2 helper, FSM encoding, frame constants.
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  // PARITY is only visited when UART_RX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_PARITY    = 3'd4,
    ST_STOP      = 3'd5
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with registered first-word-fall-through head.
// Latency: a push is visible on head_o/empty_o the clock after it is accepted.
// Backpressure: push while full is refused unless a pop happens in the same cycle.
// Ports: clk_i/rst_i (async active-high), push_i/push_dat_i, pop_i,
//        head_o (holds last head when empty), empty_o, full_o, count_o.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = clog2_f(DEPTH),
  localparam int CW = clog2_f(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             empty_o,
  output logic             full_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    wr_ptr_d = wr_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    rd_ptr_d = rd_ptr_q;
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);

    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);

    // Next head: hold when going empty; take the incoming byte if no older
    // entry survives this cycle; otherwise the stored entry at the new rd ptr.
    head_d = head_q;
    if (count_d != '0) begin
      if (count_q == (do_pop ? CW'(1) : CW'(0))) head_d = push_dat_i;
      else                                       head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage carries no reset; entries are only read once written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

  assign head_o  = head_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_reader.sv
// uart_rx_reader: RS-232 receive path; 2-flop sync, 8N1 deframer, FIFO popped by TRG_READ.
// Latency: byte on READY/DATA_OUT one clock after the stop-bit mid-sample.
// Backpressure: FLOW=0 when <2 entries free; byte arriving on a full FIFO is dropped (OVERRUN).
// Ports: CLK_50MHZ, RST (async active-high), RX (async serial), TRG_READ (pop on rising edge),
//        DATA_OUT[7:0] (FWFT head), READY (non-empty), FLOW, FRAME_ERR, OVERRUN (pulses).
// Build option: define UART_RX_PARITY_EN for 8E1 framing, adding the PAR_ERR pulse output.
module uart_rx_reader
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       RX,
  input  logic       TRG_READ,
  output logic [7:0] DATA_OUT,
  output logic       READY,
  output logic       FLOW,
  output logic       FRAME_ERR,
`ifdef UART_RX_PARITY_EN
  output logic       PAR_ERR,
`endif
  output logic       OVERRUN
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int CNT_W = clog2_f(DIV);
  localparam int CW    = clog2_f(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIV / 2);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(DIV - 1);

  // ---------------- input synchroniser (idle-high reset) ----------------
  logic sync1_q, rxs_q;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= RX;
      rxs_q   <= sync1_q;
    end
  end

  // ---------------- deframer FSM ----------------
  rx_state_e              state_q;
  logic [CNT_W-1:0]       bit_cnt_q;
  logic [2:0]             bit_idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   frame_err_q;
  logic                   cnt_zero;
  logic                   push_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q;
  logic                   par_err_q;
  logic                   par_bad;
  assign par_bad = (par_bit_q != ^shift_q);
`endif

  assign cnt_zero = (bit_cnt_q == '0);

  // The push happens on the stop-sample cycle itself.
  always_comb begin
    push_d = (state_q == ST_STOP) && cnt_zero && (rxs_q == STOP_LEVEL);
`ifdef UART_RX_PARITY_EN
    if (par_bad) push_d = 1'b0;
`endif
  end

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      state_q     <= ST_WAIT_IDLE;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q   <= 1'b0;
`endif
      case (state_q)
        ST_WAIT_IDLE: begin
          if (rxs_q) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!rxs_q) begin
            bit_cnt_q <= HALF_BIT;
            state_q   <= ST_START;
          end
        end
        ST_START: begin
          if (cnt_zero) begin
            if (!rxs_q) begin
              bit_cnt_q <= RELOAD;
              bit_idx_q <= '0;
              state_q   <= ST_DATA;
            end else begin
              // Line went back high before mid start bit: glitch, no flag.
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_zero) begin
            shift_q   <= {rxs_q, shift_q[DATA_BITS-1:1]};  // LSB first
            bit_cnt_q <= RELOAD;
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_zero) begin
            par_bit_q <= rxs_q;
            bit_cnt_q <= RELOAD;
            state_q   <= ST_STOP;
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_zero) begin
            if (rxs_q != STOP_LEVEL) begin
              // Wait for line high again so a break cannot retrigger a frame.
              frame_err_q <= 1'b1;
              state_q     <= ST_WAIT_IDLE;
            end else begin
`ifdef UART_RX_PARITY_EN
              if (par_bad) par_err_q <= 1'b1;
`endif
              state_q <= ST_IDLE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_WAIT_IDLE;
      endcase
    end
  end

  // ---------------- pop edge detect, flow, overrun ----------------
  logic            trg_q;
  logic            pop;
  logic            flow_q;
  logic            overrun_q;
  logic [7:0]      fifo_head;
  logic            fifo_empty;
  logic            fifo_full;
  logic [CW-1:0]   fifo_count;

  // One pop per rising edge of TRG_READ, however long it stays high.
  assign pop = TRG_READ && !trg_q;

  always_ff @(posedge CLK_50MHZ or posedge RST) begin
    if (RST) begin
      trg_q     <= 1'b0;
      flow_q    <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      trg_q     <= TRG_READ;
      flow_q    <= (fifo_count < CW'(FIFO_DEPTH - 1));
      // Dropped only when full and the head is not leaving this cycle.
      overrun_q <= push_d && fifo_full && !(pop && !fifo_empty);
    end
  end

  uart_rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK_50MHZ),
    .rst_i      (RST),
    .push_i     (push_d),
    .push_dat_i (shift_q),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full),
    .count_o    (fifo_count)
  );

  assign DATA_OUT  = fifo_head;
  assign READY     = !fifo_empty;
  assign FLOW      = flow_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign PAR_ERR   = par_err_q;
`endif

endmodule
